lsu_writeback_unit: RTL
=======================

Name: lsu_writeback_unit

Overview:
Write-back stage directly downstream of the load/store unit in the multi-cycle RV32 core. It captures the execute-stage result, waits for load data when the instruction is a load, and commits the result to the integer register file. It then pulses a one-cycle valid with the next PC to the fetch unit. It owns the register file and supplies two asynchronous read ports to decode.

Parameters:
XLEN, 32, datapath width in bits.
NR_REGS, 32, number of architectural integer registers.
REG_AW, 5, register index width.

Ports:
i_clock  in  1  clock, rising edge.
i_reset  in  1  synchronous active-high reset.
i_valid  in  1  one-cycle pulse from execute: instruction ready for write-back.
i_rd  in  REG_AW  destination register index.
i_rd_wen  in  1  instruction writes rd.
i_is_load  in  1  result comes from the LSU, not the ALU.
i_alu_result  in  XLEN  execute result; used when i_is_load=0.
i_next_pc  in  XLEN  PC of the next instruction.
i_lsu_valid  in  1  one-cycle pulse: LSU load data is valid.
i_lsu_rdata  in  XLEN  LSU load data, already extended.
i_rs1  in  REG_AW  read port 1 index.
i_rs2  in  REG_AW  read port 2 index.
o_rs1_data  out  XLEN  read port 1 data, combinational.
o_rs2_data  out  XLEN  read port 2 data, combinational.
o_valid  out  1  one-cycle commit pulse to fetch.
o_next_pc  out  XLEN  registered next PC; meaningful while o_valid=1.
o_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: clock i_clock; reset i_reset is synchronous and active-high.
- Reset values: state=IDLE, o_valid=0, o_busy=0, o_next_pc=0, all registers=0. Reset asserted mid-operation abandons the instruction; no register write occurs.
- Finite state machine (FSM) states: IDLE, WAIT_LSU, COMMIT.
- IDLE:
  - On i_valid, latch rd, rd_wen, is_load, next_pc, and alu_result into the write-back data register.
  - Next state is WAIT_LSU if is_load=1, else COMMIT.
- WAIT_LSU:
  - Hold until i_lsu_valid.
  - On i_lsu_valid, latch i_lsu_rdata into the write-back data register; next state COMMIT.
  - No timeout.
- COMMIT:
  - o_valid=1 for exactly this cycle.
  - At the end of the cycle, write the write-back data to rd if rd_wen=1 and rd!=0.
  - Next state IDLE.
- o_valid and o_busy are decoded from the registered state, so there is no combinational path from any input to either output.
- Latency:
  - Non-load: i_valid at cycle N, o_valid at N+1; the write is visible on the read ports at N+2.
  - Load: i_lsu_valid at cycle M, o_valid at M+1; the write is visible at M+2.
- Reads: asynchronous. Index 0 always returns 0. There is no write-to-read bypass: a read during COMMIT returns the old value.
- i_valid outside IDLE is ignored; upstream guarantees it does not occur while o_busy=1.
- i_lsu_valid in IDLE or COMMIT is ignored.
- i_lsu_valid in the same cycle as i_valid (IDLE) is ignored; the load still waits for a later i_lsu_valid.
- rd=0 with rd_wen=1: o_valid still pulses and no register changes.
- The write-back data register is XLEN wide with no truncation; sign or zero extension is the LSU's responsibility.

Optional Feature:
Macro: WBU_RVE_EN.
- Defined: NR_REGS is 16 (RV32E).
  - Writes with rd[4]=1 are suppressed, but o_valid still pulses.
  - Reads with rs[4]=1 return 0.
  - Storage is 15 registers.
- Undefined: 32 registers, all 5 index bits decoded.

Decomposition:
- Shared package wbu_pkg:
  - XLEN and REG_AW constants.
  - NR_REGS constant, selected by WBU_RVE_EN.
  - State typedef wbu_state_t {IDLE, WAIT_LSU, COMMIT}.
- Sub-module wbu_regfile:
  - One write port (wen, waddr, wdata).
  - Two asynchronous read ports.
  - x0 hardwired to 0; synchronous reset clears all entries.
- The FSM and the latch registers live in the top module.

Test Plan:
- Non-load, i_rd=5, i_rd_wen=1, i_alu_result=0x12345678, i_next_pc=0x80000004 -> o_valid at N+1 with o_next_pc=0x80000004; o_rs1_data=0x12345678 at N+2 with i_rs1=5.
- Load, i_rd=10; i_lsu_valid after 3 cycles with i_lsu_rdata=0xFFFFFF80 -> o_busy high throughout; o_valid exactly 1 cycle after i_lsu_valid; x10=0xFFFFFF80. The latched ALU value is not written.
- i_rd=0, i_rd_wen=1, data 0xDEADBEEF -> o_valid pulses; read of index 0 returns 0.
- i_rd_wen=0, i_rd=7 -> o_valid pulses; x7 unchanged. A spurious i_lsu_valid in IDLE causes no state change and no o_valid.
- Reset asserted during WAIT_LSU -> next cycle o_busy=0, o_valid=0, all registers 0; a later i_lsu_valid produces no o_valid.
- With WBU_RVE_EN defined, write x20=0x55 -> o_valid pulses; reading 20 returns 0; x4 write/read behaves normally.

Source files
------------

// File: rtl/wbu_pkg.sv
// Shared constants and state type for the write-back unit.
// WBU_RVE_EN selects the 16-register RV32E register file.
package wbu_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
`ifdef WBU_RVE_EN
    localparam int NR_REGS = 16;
`else
    localparam int NR_REGS = 32;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LSU = 2'd1,
        COMMIT   = 2'd2
    } wbu_state_t;
endpackage

// File: rtl/wbu_regfile.sv
// Integer register file: one synchronous write port, two asynchronous read ports.
// Depth follows wbu_pkg::NR_REGS (16 when WBU_RVE_EN is defined); x0 is not stored.
module wbu_regfile
    import wbu_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_wen,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [XLEN-1:0]   o_rdata1,
    output logic [XLEN-1:0]   o_rdata2
);
    logic [XLEN-1:0] regs_reg [1:NR_REGS-1];

    // Indices outside 1..NR_REGS-1 never match, so x0 and RV32E upper indices are inert.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 1; i < NR_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (i_wen) begin
            for (int i = 1; i < NR_REGS; i++) begin
                if (i_waddr == REG_AW'(i)) begin
                    regs_reg[i] <= i_wdata;
                end
            end
        end
    end

    always_comb begin
        o_rdata1 = '0;
        for (int i = 1; i < NR_REGS; i++) begin
            if (i_raddr1 == REG_AW'(i)) begin
                o_rdata1 = regs_reg[i];
            end
        end
    end

    always_comb begin
        o_rdata2 = '0;
        for (int i = 1; i < NR_REGS; i++) begin
            if (i_raddr2 == REG_AW'(i)) begin
                o_rdata2 = regs_reg[i];
            end
        end
    end
endmodule

// File: rtl/lsu_writeback_unit.sv
// Write-back stage: latches the execute result, waits for load data, commits to the
// register file and pulses o_valid with the next PC. WBU_RVE_EN shrinks the file to RV32E.
module lsu_writeback_unit
    import wbu_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_rd_wen,
    input  logic              i_is_load,
    input  logic [XLEN-1:0]   i_alu_result,
    input  logic [XLEN-1:0]   i_next_pc,
    input  logic              i_lsu_valid,
    input  logic [XLEN-1:0]   i_lsu_rdata,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    output logic [XLEN-1:0]   o_rs1_data,
    output logic [XLEN-1:0]   o_rs2_data,
    output logic              o_valid,
    output logic [XLEN-1:0]   o_next_pc,
    output logic              o_busy
);
    wbu_state_t        state_reg;
    logic [REG_AW-1:0] rd_reg;
    logic              rd_wen_reg;
    logic [XLEN-1:0]   next_pc_reg;
    logic [XLEN-1:0]   wb_data_reg;

    // The load/ALU distinction is carried by the state itself, so is_load needs no register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg   <= IDLE;
            rd_reg      <= '0;
            rd_wen_reg  <= 1'b0;
            next_pc_reg <= '0;
            wb_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        rd_reg      <= i_rd;
                        rd_wen_reg  <= i_rd_wen;
                        next_pc_reg <= i_next_pc;
                        wb_data_reg <= i_alu_result;
                        state_reg   <= i_is_load ? WAIT_LSU : COMMIT;
                    end
                end
                WAIT_LSU: begin
                    if (i_lsu_valid) begin
                        wb_data_reg <= i_lsu_rdata;
                        state_reg   <= COMMIT;
                    end
                end
                COMMIT:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_valid   = (state_reg == COMMIT);
    assign o_busy    = (state_reg != IDLE);
    assign o_next_pc = next_pc_reg;

    wbu_regfile u_regfile (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_wen    (o_valid && rd_wen_reg),
        .i_waddr  (rd_reg),
        .i_wdata  (wb_data_reg),
        .i_raddr1 (i_rs1),
        .i_raddr2 (i_rs2),
        .o_rdata1 (o_rs1_data),
        .o_rdata2 (o_rs2_data)
    );
endmodule
